// File: rtl/aes_dec_scheduler.sv
// Job scheduler that sits in front of an AES decryptor. It holds the 11-entry
// round-key table, sequences reset and enable for each job, and returns the plaintext.
module aes_dec_scheduler #(
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         KeyWe,
  input  logic [3:0]   KeyAddr,
  input  logic [127:0] KeyData,
  output logic         KeysLoaded,
  input  logic         InValid,
  input  logic [127:0] InCT,
  output logic         InReady,
  output logic         OutValid,
  output logic [127:0] OutPT,
  input  logic         OutReady,
  output logic         Err,
  output logic         Busy,
  output logic         DecRst,
  output logic         DecEn,
  output logic [127:0] DecCT,
  input  logic [3:0]   DecSelKey,
  output logic [127:0] DecKey,
  input  logic         DecRy,
  input  logic [127:0] DecPT
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [TCW-1:0] RUN_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RSTD, RUN, DONE} state_t;

  state_t         state_r, next_s;
  logic [RCW-1:0] rst_cnt_r;
  logic [TCW-1:0] run_cnt_r;
  logic [10:0]    key_mask_r;
  logic [127:0]   key_tbl_r [0:10];
  logic [127:0]   ct_r, pt_r, dec_key_s;
  logic           out_valid_r, err_r;
  logic           in_ready_s, accept_s, key_wr_s;

  assign KeysLoaded = &key_mask_r;
  assign in_ready_s = (state_r == IDLE) & KeysLoaded & ~out_valid_r;
  assign accept_s   = InValid & in_ready_s;
  // A write in the accept cycle still lands: the state is still IDLE.
  assign key_wr_s   = KeyWe & (KeyAddr <= 4'd10) & (state_r == IDLE);

  assign InReady  = in_ready_s;
  assign OutValid = out_valid_r;
  assign OutPT    = pt_r;
  assign Err      = err_r;
  assign Busy     = (state_r != IDLE);
  assign DecRst   = (state_r == RSTD);
  assign DecEn    = (state_r == RUN);
  assign DecCT    = ct_r;
  assign DecKey   = dec_key_s;

  // Round-key lookup for the decryptor; out-of-range indices fall back to key 0
  always_comb begin
    dec_key_s = key_tbl_r[0];
    if (DecSelKey <= 4'd10) begin
      dec_key_s = key_tbl_r[DecSelKey];
    end else begin
      dec_key_s = key_tbl_r[0];
    end
  end

  // Next-state logic of the job sequencer
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: if (accept_s) next_s = RSTD; else next_s = IDLE;
      RSTD: if (rst_cnt_r == RST_LAST) next_s = RUN; else next_s = RSTD;
      RUN: begin
        if (DecRy) begin
          next_s = DONE;
        end else if (run_cnt_r == RUN_LAST) begin
          next_s = IDLE;
        end else begin
          next_s = RUN;
        end
      end
      DONE: if (out_valid_r & OutReady) next_s = IDLE; else next_s = DONE;
      default: next_s = IDLE;
    endcase
  end

  // Key table storage; contents deliberately survive Rst, only the mask is cleared
  always_ff @(posedge Clk) begin
    if (key_wr_s) begin
      key_tbl_r[KeyAddr] <= KeyData;
    end
  end

  // State, counters, key mask and registered job/result data
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= IDLE;
      rst_cnt_r   <= '0;
      run_cnt_r   <= '0;
      key_mask_r  <= 11'd0;
      ct_r        <= 128'd0;
      pt_r        <= 128'd0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r <= next_s;
      err_r   <= 1'b0;
      if (key_wr_s) begin
        key_mask_r[KeyAddr] <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          rst_cnt_r <= '0;
          run_cnt_r <= '0;
          if (accept_s) begin
            ct_r <= InCT;
          end
        end
        RSTD: begin
          rst_cnt_r <= rst_cnt_r + RCW'(1);
          run_cnt_r <= '0;
        end
        RUN: begin
          if (DecRy) begin
            pt_r        <= DecPT;
            out_valid_r <= 1'b1;
          end else if (run_cnt_r == RUN_LAST) begin
            err_r <= 1'b1;
          end else begin
            run_cnt_r <= run_cnt_r + TCW'(1);
          end
        end
        DONE: begin
          if (OutReady) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          rst_cnt_r <= '0;
          run_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
